jtframe_ioctl_pack: RTL

//  Sits directly downstream of the MiST/MiSTer data_io ioctl byte stream during ROM download.

---
 rtl/jtframe_ioctl_pack.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/jtframe_ioctl_pack.sv
// jtframe_ioctl_pack: turns the ioctl download byte stream into held, masked
// 16-bit SDRAM write requests, with an optional header skip and a PROM side port.
module jtframe_ioctl_pack #(
  parameter int          HEADER     = 0,
  parameter logic [24:0] PROM_START = 25'h1FFFFFF,
  parameter int          PROMW      = 10,
  parameter bit          SWAB       = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             downloading_i,
  input  logic [24:0]      ioctl_addr_i,
  input  logic [7:0]       ioctl_dout_i,
  input  logic             ioctl_wr_i,
  output logic [21:0]      prog_addr_o,
  output logic [15:0]      prog_data_o,
  output logic [1:0]       prog_mask_o,
  output logic             prog_we_o,
  input  logic             prog_rdy_i,
  output logic             prom_we_o,
  output logic [PROMW-1:0] prom_addr_o,
  output logic [7:0]       prom_data_o,
  output logic             dwnld_busy_o,
  output logic             overflow_o
);

  localparam logic [24:0] HEADER_W = 25'(HEADER);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  // FIFO entry: {eff[22:0], byte}. eff[24:23] never reach prog_addr (the word
  // address wraps modulo 2^22), so they are dropped at push time.
  localparam int ENTRY_W = 31;

  logic [ENTRY_W-1:0] fifo_mem [4];
  logic [1:0]         wr_ptr_q, rd_ptr_q;
  logic [2:0]         count_q;
  logic               overflow_q;
  logic               dl_q;
  state_t             state_q;

  logic [21:0]        prog_addr_q;
  logic [15:0]        prog_data_q;
  logic [1:0]         prog_mask_q;
  logic               prog_we_q;
  logic               prom_we_q;
  logic [PROMW-1:0]   prom_addr_q;
  logic [7:0]         prom_data_q;

  logic               hdr_ok, prom_range;
  logic               byte_valid, prom_hit, push_req;
  logic               dl_rise, full, pop, push_ok, drop;
  logic [1:0]         wr_idx;
  logic [ENTRY_W-1:0] fifo_din, head;
  logic [22:0]        head_eff;
  logic [7:0]         head_byte;
  logic [2:0]         count_d;

  // A zero threshold would make the comparison constant, so it is elided.
  generate
    if (HEADER == 0) begin : g_no_header
      assign hdr_ok = 1'b1;
    end else begin : g_header
      assign hdr_ok = (ioctl_addr_i >= HEADER_W);
    end
    if (PROM_START == 25'd0) begin : g_prom_all
      assign prom_range = 1'b1;
    end else begin : g_prom_cmp
      assign prom_range = (ioctl_addr_i >= PROM_START);
    end
  endgenerate

  // Byte qualification, FIFO handshake and downloading edge detect.
  always_comb begin
    byte_valid = ioctl_wr_i & downloading_i & hdr_ok;
    prom_hit   = byte_valid & prom_range;
    push_req   = byte_valid & ~prom_range;
    dl_rise    = downloading_i & ~dl_q;
    full       = (count_q == 3'd4);
    // A flush discards the queue, so nothing is popped in that cycle.
    pop        = (state_q == IDLE) & (count_q != 3'd0) & ~dl_rise;
    push_ok    = push_req & (dl_rise | ~full | pop);
    drop       = push_req & ~dl_rise & full & ~pop;
    wr_idx     = dl_rise ? 2'd0 : wr_ptr_q;
    fifo_din   = {23'(ioctl_addr_i - HEADER_W), ioctl_dout_i};
    head       = fifo_mem[rd_ptr_q];
    head_eff   = head[ENTRY_W-1:8];
    head_byte  = head[7:0];
    count_d    = count_q + 3'(push_ok) - 3'(pop);
  end

  // FIFO storage: plain array, no reset needed since pointers gate validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_idx] <= fifo_din;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      dl_q <= downloading_i;
      if (dl_rise) begin
        // New download: start from an empty queue, keeping a same-cycle byte.
        wr_ptr_q   <= push_ok ? 2'd1 : 2'd0;
        rd_ptr_q   <= 2'd0;
        count_q    <= push_ok ? 3'd1 : 3'd0;
        overflow_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
        count_q <= count_d;
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  // PROM side port: one-cycle strobe with registered address and data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= 8'd0;
    end else begin
      prom_we_q <= prom_hit;
      if (prom_hit) begin
        prom_addr_q <= PROMW'(ioctl_addr_i - PROM_START);
        prom_data_q <= ioctl_dout_i;
      end
    end
  end

  // Request FSM: load on IDLE->REQ, hold until acknowledged, then force a gap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prog_addr_q <= 22'd0;
      prog_data_q <= 16'd0;
      prog_mask_q <= 2'b11;
      prog_we_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            prog_addr_q <= head_eff[22:1];
            prog_data_q <= {head_byte, head_byte};
            prog_mask_q <= (head_eff[0] ^ SWAB) ? 2'b01 : 2'b10;
            prog_we_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (prog_rdy_i) begin
            prog_we_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          prog_we_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign prog_addr_o  = prog_addr_q;
  assign prog_data_o  = prog_data_q;
  assign prog_mask_o  = prog_mask_q;
  assign prog_we_o    = prog_we_q;
  assign prom_we_o    = prom_we_q;
  assign prom_addr_o  = prom_addr_q;
  assign prom_data_o  = prom_data_q;
  assign overflow_o   = overflow_q;
  assign dwnld_busy_o = downloading_i | (count_q != 3'd0) | prog_we_q;

endmodule
